linealizador_pwl_mc: RTL and testbench
======================================

Name: linealizador_pwl_mc

Overview:
- Parametrised multi-channel piecewise-linear linearizer; successor to the single-channel linearization core.
- Each channel owns a loadable table of 2^S segments; each entry holds a slope and an offset.
- Same Begin_FSM_LN / ACK_LN handshake style as the existing core.
- Sits between the sensor normalisation stage and the summing stage; BUSY gates the upstream scheduler.

Parameters:
- W, 16: sample/result width, unsigned Q0.W.
- S, 4: segment index bits (2^S segments per channel).
- NCH, 4: channel count; CW = max(1, clog2(NCH)); F = W-S fraction bits (derived).

Ports:
- CLK  in  1  system clock
- RST_LN  in  1  synchronous active-high reset
- Begin_FSM_LN  in  1  start request; sampled in IDLE or DONE
- T  in  W  input sample
- CH  in  CW  channel of T
- CFG_WE  in  1  table write enable
- CFG_ADDR  in  CW+S  table address {channel, segment}
- CFG_SLOPE  in  W+1  signed slope
- CFG_OFFSET  in  W  unsigned offset
- ACK_LN  out  1  result valid, held
- RESULT  out  W  linearized result
- CH_OUT  out  CW  channel tag of RESULT
- O_F  out  1  overflow (saturated high)
- U_F  out  1  underflow (saturated low)
- BUSY  out  1  high in FETCH, MULT, ADD

Behaviour:
- Clocking and reset:
  - One clock, CLK; RST_LN is synchronous, active-high.
  - Reset forces state IDLE; ACK_LN, RESULT, CH_OUT, O_F, U_F, BUSY all 0.
  - Table contents unaffected by reset.
- States: IDLE, FETCH, MULT, ADD, DONE.
- IDLE or DONE with Begin_FSM_LN=1 at edge k:
  - Latch T, CH.
  - idx = T[W-1:F], frac = T[F-1:0].
  - Clear ACK_LN, O_F, U_F; go FETCH.
- FETCH (edge k+1): register slope and offset from entry {CH, idx}; go MULT.
  - Read-before-write: a CFG write to the same address on that edge is not seen.
- MULT (edges k+2 .. k+F+1): iterative shift-add, one frac bit per cycle.
  - Signed product width W+1+F.
  - Go ADD after F iterations.
- ADD (edge k+F+2):
  - sum = offset + (product >>> F), signed W+2 bits, arithmetic shift (truncation toward minus infinity).
  - sum < 0: RESULT = 0, U_F = 1.
  - sum > 2^W-1: RESULT = all ones, O_F = 1.
  - Otherwise RESULT = sum[W-1:0].
  - CH_OUT = latched CH; ACK_LN = 1; go DONE.
- Latency: ACK_LN high F+2 edges after Begin_FSM_LN is sampled (14 at defaults).
- DONE:
  - RESULT, CH_OUT, flags and ACK_LN held until a new Begin_FSM_LN or reset.
  - Begin in DONE behaves as in IDLE; ACK_LN drops on that edge.
- Begin_FSM_LN in FETCH, MULT or ADD is ignored; no queuing.
- CFG writes:
  - Accepted in any state.
  - The in-flight conversion is unaffected once FETCH has passed.
- Reset mid-operation: abort, IDLE on next edge, no ACK_LN.
- RST_LN and Begin_FSM_LN on the same edge: reset wins.

Optional Feature:
- Macro: LN_ROUND_EN.
- Defined: add 2^(F-1) before the >>> F shift (round half up); multiplier/adder widened by 1 bit as needed.
- Undefined: plain truncation as above.
- Saturation and flag rules identical in both cases.

Decomposition:
- Shared package ln_pwl_pkg:
  - state enum.
  - localparams F, CW, table depth NCH*2^S.
  - saturate function (signed W+2 to unsigned W plus O_F/U_F).
- One sub-module, ln_shift_add_mult:
  - Iterative signed(W+1) x unsigned(F) multiplier.
  - start/done handshake, F-cycle latency.
- Table is a register array inside the top module.

Test Plan (defaults W=16, S=4, F=12):
- Identity: table ch0/idx0 slope=4096, offset=0; T=0x0ABC, CH=0, Begin pulse -> ACK_LN after 14 edges, RESULT=0x0ABC, CH_OUT=0, O_F=U_F=0.
- Overflow: ch1/idx15 slope=4096, offset=0xFFF0; T=0xF100, CH=1 -> RESULT=0xFFFF, O_F=1, U_F=0, CH_OUT=1.
- Underflow: ch2/idx3 slope=-4096, offset=0x0010; T=0x3100, CH=2 -> RESULT=0x0000, U_F=1.
- Busy and reset:
  - Begin re-pulsed at edge k+5 -> ignored, single ACK_LN at k+14.
  - RST_LN at edge k+6 of a new run -> ACK_LN never rises, BUSY=0 next cycle.
  - Next Begin converts normally.
- Table isolation:
  - Same T=0x0ABC on CH=0 vs CH=3 (ch3/idx0 offset=0x0100, slope=4096) -> 0x0ABC vs 0x0BBC.
  - CFG write to ch0/idx0 during MULT does not change the in-flight result.
- Rounding: slope=1, offset=0, T=0x0800 -> RESULT=0 without LN_ROUND_EN, RESULT=1 with it.

Source files
------------

// File: rtl/ln_pwl_pkg.sv
// Shared types and helpers for the multi-channel piecewise-linear linearizer.
// Holds the default geometry, the FSM state type and the output saturation rule.
package ln_pwl_pkg;

  localparam int LN_W   = 16;
  localparam int LN_S   = 4;
  localparam int LN_NCH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MULT,
    ST_ADD,
    ST_DONE
  } ln_state_t;

  typedef struct packed {
    logic o_f;
    logic u_f;
  } ln_sat_t;

  function automatic int ln_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int ln_frac_bits(input int w, input int s);
    return w - s;
  endfunction

  function automatic int ln_depth(input int nch, input int s);
    return nch << s;
  endfunction

  // Flags for clamping a signed sum into unsigned w bits; the caller muxes the value.
  function automatic ln_sat_t saturate(input logic signed [63:0] sum, input int w);
    ln_sat_t r;
    r.o_f = 1'b0;
    r.u_f = 1'b0;
    if (sum < 64'sd0) begin
      r.u_f = 1'b1;
    end else if (sum > ((64'sd1 <<< w) - 64'sd1)) begin
      r.o_f = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ln_shift_add_mult.sv
// Iterative signed(MW) x unsigned(NB) shift-add multiplier, one multiplier bit per cycle.
// o_done is high during the last iteration; o_product is final after that edge and held.
module ln_shift_add_mult #(
  parameter int MW = 17,
  parameter int NB = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic signed [MW-1:0] i_mcand,
  input  logic [NB-1:0]        i_mplier,
  output logic                 o_done,
  output logic signed [MW+NB-1:0] o_product
);

  localparam int PW   = MW + NB;
  localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;

  logic signed [PW-1:0] r_acc;
  logic signed [PW-1:0] r_mcand;
  logic [NB-1:0]        r_mplier;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_busy;
  logic                 w_last;

  assign w_last    = r_busy && (r_cnt == CNTW'(NB - 1));
  assign o_done    = w_last;
  assign o_product = r_acc;

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= PW'(i_mcand);
      r_mplier <= i_mplier;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNTW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/linealizador_pwl_mc.sv
// Multi-channel piecewise-linear linearizer: per-channel slope/offset tables, shift-add
// multiply, saturating add. Define LN_ROUND_EN to round half up instead of truncating.
module linealizador_pwl_mc
  import ln_pwl_pkg::*;
#(
  parameter int W   = LN_W,
  parameter int S   = LN_S,
  parameter int NCH = LN_NCH,
  localparam int CW = ln_cw(NCH)
) (
  input  logic                CLK,
  input  logic                RST_LN,
  input  logic                Begin_FSM_LN,
  input  logic [W-1:0]        T,
  input  logic [CW-1:0]       CH,
  input  logic                CFG_WE,
  input  logic [CW+S-1:0]     CFG_ADDR,
  input  logic signed [W:0]   CFG_SLOPE,
  input  logic [W-1:0]        CFG_OFFSET,
  output logic                ACK_LN,
  output logic [W-1:0]        RESULT,
  output logic [CW-1:0]       CH_OUT,
  output logic                O_F,
  output logic                U_F,
  output logic                BUSY
);

  localparam int F     = ln_frac_bits(W, S);
  localparam int DEPTH = ln_depth(NCH, S);
  localparam int AW    = CW + S;
  localparam int PW    = W + 1 + F;

  logic signed [W:0]   r_tbl_slope  [DEPTH];
  logic [W-1:0]        r_tbl_offset [DEPTH];

  ln_state_t           r_state;
  logic [W-1:0]        r_t;
  logic [CW-1:0]       r_ch;
  logic [W-1:0]        r_offset;
  logic [W-1:0]        r_result;
  logic [CW-1:0]       r_ch_out;
  logic                r_ack;
  logic                r_of;
  logic                r_uf;
  logic                r_busy;

  logic [AW-1:0]       w_rd_addr;
  logic signed [W:0]   w_slope;
  logic                w_mult_start;
  logic                w_mult_done;
  logic signed [PW-1:0] w_product;
  logic signed [PW:0]  w_prod_ext;
  logic signed [W+1:0] w_sum;
  ln_sat_t             w_sat;
  logic [W-1:0]        w_result;

  // NOTE: the table has no reset; its contents must survive RST_LN, and a reset loop
  // over a memory would also prevent it from mapping onto RAM.
  always_ff @(posedge CLK) begin
    if (CFG_WE) begin
      r_tbl_slope[CFG_ADDR]  <= CFG_SLOPE;
      r_tbl_offset[CFG_ADDR] <= CFG_OFFSET;
    end
  end

  // Asynchronous read against the pre-edge table gives read-before-write in FETCH.
  assign w_rd_addr    = {r_ch, r_t[W-1:F]};
  assign w_slope      = r_tbl_slope[w_rd_addr];
  assign w_mult_start = (r_state == ST_FETCH);

  ln_shift_add_mult #(
    .MW(W + 1),
    .NB(F)
  ) u_mult (
    .i_clk    (CLK),
    .i_rst    (RST_LN),
    .i_start  (w_mult_start),
    .i_mcand  (w_slope),
    .i_mplier (r_t[F-1:0]),
    .o_done   (w_mult_done),
    .o_product(w_product)
  );

`ifdef LN_ROUND_EN
  localparam logic [PW:0] RND_K = (PW + 1)'(1) << (F - 1);
  assign w_prod_ext = $signed({w_product[PW-1], w_product} + RND_K);
`else
  assign w_prod_ext = {w_product[PW-1], w_product};
`endif

  // Dropping the low F bits of a two's-complement value is the floor (>>> F) shift.
  assign w_sum    = $signed(w_prod_ext[PW:F]) + $signed({2'b00, r_offset});
  assign w_sat    = saturate(64'(w_sum), W);
  assign w_result = w_sat.o_f ? '1 : (w_sat.u_f ? '0 : w_sum[W-1:0]);

  always_ff @(posedge CLK) begin
    if (RST_LN) begin
      r_state  <= ST_IDLE;
      r_t      <= '0;
      r_ch     <= '0;
      r_offset <= '0;
      r_result <= '0;
      r_ch_out <= '0;
      r_ack    <= 1'b0;
      r_of     <= 1'b0;
      r_uf     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Begin_FSM_LN) begin
            r_t     <= T;
            r_ch    <= CH;
            r_ack   <= 1'b0;
            r_of    <= 1'b0;
            r_uf    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_offset <= r_tbl_offset[w_rd_addr];
          r_state  <= ST_MULT;
        end
        ST_MULT: begin
          if (w_mult_done) begin
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_result <= w_result;
          r_of     <= w_sat.o_f;
          r_uf     <= w_sat.u_f;
          r_ch_out <= r_ch;
          r_ack    <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ACK_LN = r_ack;
  assign RESULT = r_result;
  assign CH_OUT = r_ch_out;
  assign O_F    = r_of;
  assign U_F    = r_uf;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_linealizador_pwl_mc.sv
// Self-checking bench for linealizador_pwl_mc: fixed vectors, hand-timed corner sequences,
// and random conversions against an arithmetic model of the table lookup and clamp.
module tb_linealizador_pwl_mc;

  localparam int W     = 16;
  localparam int S     = 4;
  localparam int NCH   = 4;
  localparam int F     = W - S;
  localparam int CW    = 2;
  localparam int AW    = CW + S;
  localparam int DEPTH = NCH << S;
  localparam int LAT   = F + 2;
  localparam int MAXV  = (1 << W) - 1;
`ifdef LN_ROUND_EN
  localparam int RND_EXP = 1;
`else
  localparam int RND_EXP = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST_LN = 1'b1;
  logic          Begin_FSM_LN = 1'b0;
  logic [W-1:0]  T = '0;
  logic [CW-1:0] CH = '0;
  logic          CFG_WE = 1'b0;
  logic [AW-1:0] CFG_ADDR = '0;
  logic [W:0]    CFG_SLOPE = '0;
  logic [W-1:0]  CFG_OFFSET = '0;
  logic          ACK_LN;
  logic [W-1:0]  RESULT;
  logic [CW-1:0] CH_OUT;
  logic          O_F;
  logic          U_F;
  logic          BUSY;

  linealizador_pwl_mc dut (
    .CLK         (CLK),
    .RST_LN      (RST_LN),
    .Begin_FSM_LN(Begin_FSM_LN),
    .T           (T),
    .CH          (CH),
    .CFG_WE      (CFG_WE),
    .CFG_ADDR    (CFG_ADDR),
    .CFG_SLOPE   (CFG_SLOPE),
    .CFG_OFFSET  (CFG_OFFSET),
    .ACK_LN      (ACK_LN),
    .RESULT      (RESULT),
    .CH_OUT      (CH_OUT),
    .O_F         (O_F),
    .U_F         (U_F),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int m_slope [DEPTH];
  int m_offset[DEPTH];

  typedef struct {
    string name;
    int    ch;
    int    idx;
    int    slope;
    int    offset;
    int    t;
    int    exp_res;
    bit    exp_of;
    bit    exp_uf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Table contents are mirrored in the model arrays on every write.
  task automatic drive_cfg(input int ch, input int idx, input int slope, input int offset);
    CFG_WE     = 1'b1;
    CFG_ADDR   = AW'(ch * (1 << S) + idx);
    CFG_SLOPE  = (W + 1)'(slope);
    CFG_OFFSET = W'(offset);
    m_slope[ch * (1 << S) + idx]  = slope;
    m_offset[ch * (1 << S) + idx] = offset;
  endtask

  task automatic cfg_write(input int ch, input int idx, input int slope, input int offset);
    @(negedge CLK);
    drive_cfg(ch, idx, slope, offset);
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  // Returns at the negedge following the edge that samples Begin.
  task automatic start_conv(input int t, input int ch);
    @(negedge CLK);
    T = W'(t);
    CH = CW'(ch);
    Begin_FSM_LN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Begin_FSM_LN = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (ACK_LN !== 1'b1 && lat < 4 * LAT) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask

  task automatic idle_watch(input int cycles, output int ack_seen, output int busy_seen);
    ack_seen = 0;
    busy_seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge CLK);
      if (ACK_LN === 1'b1) ack_seen++;
      if (BUSY === 1'b1) busy_seen++;
    end
  endtask

  task automatic run_and_check(input string tag, input int t, input int ch,
                               input int exp_res, input bit exp_of, input bit exp_uf);
    int lat;
    start_conv(t, ch);
    check($sformatf("%s ack_low_after_begin", tag), ACK_LN, 0);
    check($sformatf("%s busy", tag), BUSY, 1);
    wait_ack(lat);
    check($sformatf("%s latency", tag), lat, LAT);
    check($sformatf("%s result", tag), RESULT, exp_res);
    check($sformatf("%s o_f", tag), O_F, exp_of);
    check($sformatf("%s u_f", tag), U_F, exp_uf);
    check($sformatf("%s ch_out", tag), CH_OUT, ch);
  endtask

  // result = clamp(offset + floor(slope * frac / 2^F)), with optional +0.5 LSB before flooring
  function automatic void model_conv(input int t, input int ch,
                                     output int res, output bit of, output bit uf);
    int     addr = ch * (1 << S) + (t / (1 << F));
    longint d    = longint'(1) << F;
    longint frac = longint'(t) % d;
    longint p    = longint'(m_slope[addr]) * frac;
    longint q;
    longint s;
`ifdef LN_ROUND_EN
    p = p + d / 2;
`endif
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    s = longint'(m_offset[addr]) + q;
    of = 1'b0;
    uf = 1'b0;
    if (s < 0) begin
      res = 0;
      uf = 1'b1;
    end else if (s > MAXV) begin
      res = MAXV;
      of = 1'b1;
    end else begin
      res = int'(s);
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int ack_seen;
    int busy_seen;
    int res;
    bit of;
    bit uf;

    vecs[0] = '{"identity",   0, 0,   4096, 'h0000, 'h0ABC, 'h0ABC,  1'b0, 1'b0};
    vecs[1] = '{"overflow",   1, 15,  4096, 'hFFF0, 'hF100, 'hFFFF,  1'b1, 1'b0};
    vecs[2] = '{"underflow",  2, 3,  -4096, 'h0010, 'h3100, 'h0000,  1'b0, 1'b1};
    vecs[3] = '{"ch3_offset", 3, 0,   4096, 'h0100, 'h0ABC, 'h0BBC,  1'b0, 1'b0};
    vecs[4] = '{"ch0_isolated", 0, 0, 4096, 'h0000, 'h0ABC, 'h0ABC,  1'b0, 1'b0};
    vecs[5] = '{"rounding",   1, 0,      1, 'h0000, 'h0800, RND_EXP, 1'b0, 1'b0};

    repeat (3) @(negedge CLK);
    RST_LN = 1'b0;
    check("reset ack", ACK_LN, 0);
    check("reset result", RESULT, 0);
    check("reset ch_out", CH_OUT, 0);
    check("reset o_f", O_F, 0);
    check("reset u_f", U_F, 0);
    check("reset busy", BUSY, 0);

    for (int i = 0; i < 6; i++) begin
      cfg_write(vecs[i].ch, vecs[i].idx, vecs[i].slope, vecs[i].offset);
      run_and_check(vecs[i].name, vecs[i].t, vecs[i].ch,
                    vecs[i].exp_res, vecs[i].exp_of, vecs[i].exp_uf);
    end

    // Begin re-pulsed while busy is ignored: one ACK with the first sample's result.
    start_conv('h0123, 0);
    for (int n = 1; n <= LAT; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 4) begin
        check("repulse busy_in_mult", BUSY, 1);
        T = W'('h0FFF);
        CH = CW'(3);
        Begin_FSM_LN = 1'b1;
      end
      if (n == 5) Begin_FSM_LN = 1'b0;
      if (n == LAT - 1) check("repulse no_early_ack", ACK_LN, 0);
    end
    check("repulse ack", ACK_LN, 1);
    check("repulse result", RESULT, 'h0123);
    check("repulse ch_out", CH_OUT, 0);
    idle_watch(2 * LAT, ack_seen, busy_seen);
    check("repulse ack_held", ack_seen, 2 * LAT);
    check("repulse no_second_run", busy_seen, 0);
    check("repulse result_held", RESULT, 'h0123);

    // Reset in the middle of a run aborts it.
    start_conv('h0ABC, 0);
    for (int n = 1; n <= 5; n++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    RST_LN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST_LN = 1'b0;
    check("midreset busy", BUSY, 0);
    check("midreset ack", ACK_LN, 0);
    idle_watch(2 * LAT, ack_seen, busy_seen);
    check("midreset ack_never", ack_seen, 0);
    run_and_check("after_reset", 'h0ABC, 3, 'h0BBC, 1'b0, 1'b0);

    // Reset and Begin on the same edge: reset wins.
    @(negedge CLK);
    T = W'('h0ABC);
    CH = '0;
    RST_LN = 1'b1;
    Begin_FSM_LN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST_LN = 1'b0;
    Begin_FSM_LN = 1'b0;
    check("rst_vs_begin busy", BUSY, 0);
    idle_watch(2 * LAT, ack_seen, busy_seen);
    check("rst_vs_begin ack_never", ack_seen, 0);

    // Table write during MULT does not disturb the in-flight conversion.
    start_conv('h0ABC, 0);
    for (int n = 1; n <= LAT; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 4) drive_cfg(0, 0, 0, 'h5555);
      if (n == 5) CFG_WE = 1'b0;
    end
    check("cfg_in_mult ack", ACK_LN, 1);
    check("cfg_in_mult result", RESULT, 'h0ABC);
    run_and_check("cfg_in_mult next", 'h0ABC, 0, 'h5555, 1'b0, 1'b0);

    // Write on the FETCH edge to the entry being fetched is not seen.
    cfg_write(2, 1, 4096, 'h0000);
    start_conv('h1010, 2);
    drive_cfg(2, 1, 4096, 'h7000);
    @(posedge CLK);
    @(negedge CLK);
    CFG_WE = 1'b0;
    wait_ack(lat);
    check("fetch_rbw latency", lat + 1, LAT);
    check("fetch_rbw result", RESULT, 'h0010);
    run_and_check("fetch_rbw next", 'h1010, 2, 'h7010, 1'b0, 1'b0);

    // Random tables and samples against the arithmetic model.
    for (int a = 0; a < DEPTH; a++) begin
      if (a % 2 == 0)
        cfg_write(a / (1 << S), a % (1 << S), int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, MAXV)));
      else
        cfg_write(a / (1 << S), a % (1 << S), int'($urandom_range(0, 2 * (1 << W) - 1)) - (1 << W),
                  int'($urandom_range(0, MAXV)));
    end
    for (int i = 0; i < 48; i++) begin
      int t;
      int ch;
      t = int'($urandom_range(0, MAXV));
      ch = int'($urandom_range(0, NCH - 1));
      model_conv(t, ch, res, of, uf);
      run_and_check($sformatf("rand%0d", i), t, ch, res, of, uf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
